// File: rtl/receive_slot_scheduler_if.sv
// ---------------------------------------------------------------------------
// receive_slot_scheduler_if
// Bundles the parser/fabric control pulses and the scheduler status outputs.
//   master : parser + fabric side (drives enable, frame_start, good_packet,
//            bad_packet, slot_release; observes scheduler status)
//   slave  : the scheduler (consumes the pulses, drives recieve_slot_enable,
//            slot_full, full_slot_count, receiving, dropped_frame_count)
// ---------------------------------------------------------------------------
interface receive_slot_scheduler_if #(
   parameter int RECEIVE_QUE_SLOTS = 4,
   parameter int DROP_COUNT_WIDTH  = 16
) ();
   localparam int CW = $clog2(RECEIVE_QUE_SLOTS + 1);

   logic                          enable;
   logic                          frame_start;
   logic [RECEIVE_QUE_SLOTS-1:0]  good_packet;
   logic [RECEIVE_QUE_SLOTS-1:0]  bad_packet;
   logic [RECEIVE_QUE_SLOTS-1:0]  slot_release;
   logic [RECEIVE_QUE_SLOTS-1:0]  recieve_slot_enable;
   logic [RECEIVE_QUE_SLOTS-1:0]  slot_full;
   logic [CW-1:0]                 full_slot_count;
   logic                          receiving;
   logic [DROP_COUNT_WIDTH-1:0]   dropped_frame_count;

   modport master (
      output enable, frame_start, good_packet, bad_packet, slot_release,
      input  recieve_slot_enable, slot_full, full_slot_count, receiving, dropped_frame_count
   );

   modport slave (
      input  enable, frame_start, good_packet, bad_packet, slot_release,
      output recieve_slot_enable, slot_full, full_slot_count, receiving, dropped_frame_count
   );
endinterface

// File: rtl/receive_slot_scheduler.sv
// ---------------------------------------------------------------------------
// receive_slot_scheduler
// Chooses which receive queue slot the parser writes the next frame into,
// tracks which slots hold good frames waiting for the fabric, and counts
// frames that arrived while no slot was armed.
//   clock   : block clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : receive_slot_scheduler_if.slave (pulses in, status out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module receive_slot_scheduler #(
   parameter int RECEIVE_QUE_SLOTS = 4,
   parameter int DROP_COUNT_WIDTH  = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   receive_slot_scheduler_if.slave  bus
);
   localparam int N  = RECEIVE_QUE_SLOTS;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      ST_DISABLED  = 2'd0,
      ST_WAIT_SLOT = 2'd1,
      ST_ARMED     = 2'd2,
      ST_RECEIVING = 2'd3
   } state_t;

   state_t                      state_r, state_nxt_s;
   logic [PW-1:0]               ptr_r, ptr_nxt_s;
   logic [N-1:0]                slot_full_r, slot_full_nxt_s;
   logic [N-1:0]                slot_en_r, slot_en_nxt_s;
   logic [CW-1:0]               full_cnt_r;
   logic                        receiving_r;
   logic [DROP_COUNT_WIDTH-1:0] drop_cnt_r, drop_cnt_nxt_s;

   logic                        live_s, good_hit_s, bad_hit_s, found_s;
   logic [PW-1:0]               found_idx_s, search_base_s;

   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = {CW{1'b0}};
      for (int i = 0; i < N; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offset);
      return PW'((int'(base) + offset) % N);
   endfunction

   // Only the armed slot's completion pulses matter; good+bad together counts as bad.
   assign live_s     = (state_r == ST_ARMED) || (state_r == ST_RECEIVING);
   assign bad_hit_s  = live_s && bus.bad_packet[ptr_r];
   assign good_hit_s = live_s && bus.good_packet[ptr_r] && !bus.bad_packet[ptr_r];

   // Leaving DISABLED re-checks the current slot first; every other search starts one past it.
   assign search_base_s = (state_r == ST_DISABLED) ? ptr_r : wrap_idx(ptr_r, 1);

   // Slot occupancy after this cycle: releases clear, a good completion of the armed slot sets.
   always_comb begin
      slot_full_nxt_s = slot_full_r & ~bus.slot_release;
      for (int i = 0; i < N; i++) begin
         slot_full_nxt_s[i] = slot_full_nxt_s[i] | (good_hit_s && (ptr_r == PW'(i)));
      end
   end

   // Round-robin scan for the first empty slot, seeing this cycle's releases and fills.
   always_comb begin
      logic          hit_v;
      logic [PW-1:0] idx_v;
      found_s     = 1'b0;
      found_idx_s = ptr_r;
      hit_v       = 1'b0;
      idx_v       = ptr_r;
      for (int i = 0; i < N; i++) begin
         idx_v       = wrap_idx(search_base_s, i);
         hit_v       = !found_s && !slot_full_nxt_s[idx_v];
         found_idx_s = hit_v ? idx_v : found_idx_s;
         found_s     = found_s | hit_v;
      end
   end

   // Next state and next armed pointer.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      case (state_r)
         ST_DISABLED: begin
            if (bus.enable) begin
               state_nxt_s = found_s ? ST_ARMED : ST_WAIT_SLOT;
               ptr_nxt_s   = found_s ? found_idx_s : ptr_r;
            end else begin
               state_nxt_s = ST_DISABLED;
            end
         end
         ST_WAIT_SLOT: begin
            if (!bus.enable) begin
               state_nxt_s = ST_DISABLED;
            end else if (found_s) begin
               state_nxt_s = ST_ARMED;
               ptr_nxt_s   = found_idx_s;
            end else begin
               state_nxt_s = ST_WAIT_SLOT;
            end
         end
         ST_ARMED, ST_RECEIVING: begin
            if (bad_hit_s) begin
               // Aborted frame: the same slot is reused.
               state_nxt_s = bus.enable ? ST_ARMED : ST_DISABLED;
            end else if (good_hit_s) begin
               // Pointer moves even when disabling so the next enable resumes there.
               ptr_nxt_s   = found_s ? found_idx_s : ptr_r;
               state_nxt_s = !bus.enable ? ST_DISABLED : (found_s ? ST_ARMED : ST_WAIT_SLOT);
            end else if (state_r == ST_RECEIVING) begin
               state_nxt_s = ST_RECEIVING;
            end else if (bus.frame_start) begin
               state_nxt_s = ST_RECEIVING;
            end else if (!bus.enable) begin
               state_nxt_s = ST_DISABLED;
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         default: begin
            state_nxt_s = ST_DISABLED;
            ptr_nxt_s   = {PW{1'b0}};
         end
      endcase
   end

   // One-hot slot enable for the next cycle, zero unless a slot will be armed.
   always_comb begin
      slot_en_nxt_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         slot_en_nxt_s[i] = ((state_nxt_s == ST_ARMED) || (state_nxt_s == ST_RECEIVING))
                            && (ptr_nxt_s == PW'(i));
      end
   end

   // Dropped-frame counter: frames that start with no slot armed, saturating.
   always_comb begin
      if (bus.frame_start && ((state_r == ST_DISABLED) || (state_r == ST_WAIT_SLOT))
          && !(&drop_cnt_r)) begin
         drop_cnt_nxt_s = drop_cnt_r + DROP_COUNT_WIDTH'(1'b1);
      end else begin
         drop_cnt_nxt_s = drop_cnt_r;
      end
   end

   // State, slot flags and every output update together on the clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_DISABLED;
         ptr_r       <= {PW{1'b0}};
         slot_full_r <= {N{1'b0}};
         slot_en_r   <= {N{1'b0}};
         full_cnt_r  <= {CW{1'b0}};
         receiving_r <= 1'b0;
         drop_cnt_r  <= {DROP_COUNT_WIDTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         ptr_r       <= ptr_nxt_s;
         slot_full_r <= slot_full_nxt_s;
         slot_en_r   <= slot_en_nxt_s;
         full_cnt_r  <= popcount(slot_full_nxt_s);
         receiving_r <= (state_nxt_s == ST_RECEIVING);
         drop_cnt_r  <= drop_cnt_nxt_s;
      end
   end

   assign bus.recieve_slot_enable = slot_en_r;
   assign bus.slot_full           = slot_full_r;
   assign bus.full_slot_count     = full_cnt_r;
   assign bus.receiving           = receiving_r;
   assign bus.dropped_frame_count = drop_cnt_r;
endmodule

// File: tb/tb_receive_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_receive_slot_scheduler
// Drives three schedulers from one stimulus stream: N=4/16-bit counter,
// N=4/2-bit counter (saturation) and N=1. Each is compared every cycle
// against its own behavioural model; a directed prologue also pins
// hand-computed values on the N=4 instances.
// ---------------------------------------------------------------------------
module tb_receive_slot_scheduler;
   localparam logic [1:0] S_DIS = 2'd0, S_WAIT = 2'd1, S_ARM = 2'd2, S_RX = 2'd3;

   typedef struct packed {
      logic [1:0]  st;
      logic [2:0]  ptr;
      logic [7:0]  full;
      logic [31:0] drop;
   } mdl_t;

   logic       clock, reset_n;
   logic       en, fs;
   logic [3:0] g, b, r;
   int         tests, fails;
   mdl_t       m_a, m_b, m_c;

   receive_slot_scheduler_if #(.RECEIVE_QUE_SLOTS(4), .DROP_COUNT_WIDTH(16)) bus_a ();
   receive_slot_scheduler_if #(.RECEIVE_QUE_SLOTS(4), .DROP_COUNT_WIDTH(2))  bus_b ();
   receive_slot_scheduler_if #(.RECEIVE_QUE_SLOTS(1), .DROP_COUNT_WIDTH(8))  bus_c ();

   assign bus_a.enable = en;  assign bus_a.frame_start = fs;
   assign bus_a.good_packet = g;  assign bus_a.bad_packet = b;  assign bus_a.slot_release = r;
   assign bus_b.enable = en;  assign bus_b.frame_start = fs;
   assign bus_b.good_packet = g;  assign bus_b.bad_packet = b;  assign bus_b.slot_release = r;
   assign bus_c.enable = en;  assign bus_c.frame_start = fs;
   assign bus_c.good_packet = g[0];  assign bus_c.bad_packet = b[0];  assign bus_c.slot_release = r[0];

   receive_slot_scheduler #(.RECEIVE_QUE_SLOTS(4), .DROP_COUNT_WIDTH(16)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(bus_a));
   receive_slot_scheduler #(.RECEIVE_QUE_SLOTS(4), .DROP_COUNT_WIDTH(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(bus_b));
   receive_slot_scheduler #(.RECEIVE_QUE_SLOTS(1), .DROP_COUNT_WIDTH(8)) dut_c (
      .clock(clock), .reset_n(reset_n), .bus(bus_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   function automatic int find_free(input logic [7:0] full, input int start, input int n);
      for (int i = 0; i < n; i++) begin
         int idx;
         idx = (start + i) % n;
         if (!full[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t q;
      q = '{st: S_DIS, ptr: 3'd0, full: 8'd0, drop: 32'd0};
      return q;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int n, input logic [31:0] dmax,
                                     input logic e, input logic f, input logic [7:0] gg,
                                     input logic [7:0] bb, input logic [7:0] rr);
      mdl_t q;
      logic live, hb, hg;
      logic [7:0] mask;
      int fr;
      q    = m;
      mask = 8'((9'd1 << n) - 9'd1);
      live = (m.st == S_ARM) || (m.st == S_RX);
      hb   = live && bb[m.ptr];
      hg   = live && gg[m.ptr] && !bb[m.ptr];
      q.full = m.full & ~rr & mask;
      if (hg) q.full[m.ptr] = 1'b1;
      if (f && (m.st == S_DIS || m.st == S_WAIT) && m.drop < dmax) q.drop = m.drop + 32'd1;
      case (m.st)
         S_DIS: if (e) begin
            fr = find_free(q.full, int'(m.ptr), n);
            if (fr >= 0) begin q.st = S_ARM; q.ptr = 3'(fr); end
            else q.st = S_WAIT;
         end
         S_WAIT: if (!e) q.st = S_DIS;
         else begin
            fr = find_free(q.full, int'(m.ptr) + 1, n);
            if (fr >= 0) begin q.st = S_ARM; q.ptr = 3'(fr); end
         end
         default: begin
            if (hb) q.st = e ? S_ARM : S_DIS;
            else if (hg) begin
               fr = find_free(q.full, int'(m.ptr) + 1, n);
               if (fr >= 0) q.ptr = 3'(fr);
               q.st = !e ? S_DIS : ((fr >= 0) ? S_ARM : S_WAIT);
            end else if (m.st == S_ARM) q.st = f ? S_RX : (e ? S_ARM : S_DIS);
         end
      endcase
      return q;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_a <= mdl_reset();
         m_b <= mdl_reset();
         m_c <= mdl_reset();
      end else begin
         m_a <= mdl_step(m_a, 4, 32'd65535, en, fs, {4'd0, g}, {4'd0, b}, {4'd0, r});
         m_b <= mdl_step(m_b, 4, 32'd3,     en, fs, {4'd0, g}, {4'd0, b}, {4'd0, r});
         m_c <= mdl_step(m_c, 1, 32'd255,   en, fs, {4'd0, g}, {4'd0, b}, {4'd0, r});
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input mdl_t m, input logic [31:0] rse,
                            input logic [31:0] full, input logic [31:0] cnt,
                            input logic [31:0] rx, input logic [31:0] drop);
      logic [31:0] er;
      er = (m.st == S_ARM || m.st == S_RX) ? (32'd1 << m.ptr) : 32'd0;
      chk({tag, ".recieve_slot_enable"}, rse, er);
      chk({tag, ".slot_full"}, full, 32'(m.full));
      chk({tag, ".full_slot_count"}, cnt, 32'($countones(m.full)));
      chk({tag, ".receiving"}, rx, 32'(m.st == S_RX));
      chk({tag, ".dropped_frame_count"}, drop, m.drop);
   endtask

   task automatic check_all();
      check_dut("a", m_a, 32'(bus_a.recieve_slot_enable), 32'(bus_a.slot_full),
                32'(bus_a.full_slot_count), 32'(bus_a.receiving), 32'(bus_a.dropped_frame_count));
      check_dut("b", m_b, 32'(bus_b.recieve_slot_enable), 32'(bus_b.slot_full),
                32'(bus_b.full_slot_count), 32'(bus_b.receiving), 32'(bus_b.dropped_frame_count));
      check_dut("c", m_c, 32'(bus_c.recieve_slot_enable), 32'(bus_c.slot_full),
                32'(bus_c.full_slot_count), 32'(bus_c.receiving), 32'(bus_c.dropped_frame_count));
   endtask

   task automatic lit_a(input string nm, input logic [3:0] rse, input logic [3:0] full,
                        input logic rx);
      chk({nm, ".rse"},  32'(bus_a.recieve_slot_enable), 32'(rse));
      chk({nm, ".full"}, 32'(bus_a.slot_full), 32'(full));
      chk({nm, ".rx"},   32'(bus_a.receiving), 32'(rx));
   endtask

   // one clock: drive inputs after the falling edge, check after the rising edge
   task automatic cyc(input logic e, input logic f, input logic [3:0] gg,
                      input logic [3:0] bb, input logic [3:0] rr);
      @(negedge clock);
      en = e; fs = f; g = gg; b = bb; r = rr;
      @(posedge clock);
      #1;
      check_all();
   endtask

   initial begin
      tests = 0; fails = 0;
      reset_n = 1'b0; en = 1'b0; fs = 1'b0; g = 4'd0; b = 4'd0; r = 4'd0;
      #12;
      lit_a("reset", 4'b0000, 4'b0000, 1'b0);
      chk("reset.count", 32'(bus_a.full_slot_count), 32'd0);
      chk("reset.drop",  32'(bus_a.dropped_frame_count), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);  lit_a("arm0",  4'b0001, 4'b0000, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);  lit_a("rx0",   4'b0001, 4'b0000, 1'b1);
      cyc(1'b1, 1'b0, 4'd1, 4'd0, 4'd0);  lit_a("good0", 4'b0010, 4'b0001, 1'b0);
      chk("good0.count", 32'(bus_a.full_slot_count), 32'd1);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      cyc(1'b1, 1'b0, 4'd2, 4'd0, 4'd0);  lit_a("good1", 4'b0100, 4'b0011, 1'b0);
      cyc(1'b1, 1'b0, 4'd4, 4'd0, 4'd0);  lit_a("good2", 4'b1000, 4'b0111, 1'b0);
      cyc(1'b1, 1'b0, 4'd8, 4'd0, 4'd0);  lit_a("allfull", 4'b0000, 4'b1111, 1'b0);
      chk("allfull.count", 32'(bus_a.full_slot_count), 32'd4);

      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      chk("drop3.a", 32'(bus_a.dropped_frame_count), 32'd3);
      chk("drop3.b", 32'(bus_b.dropped_frame_count), 32'd3);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      chk("drop5.a", 32'(bus_a.dropped_frame_count), 32'd5);
      chk("drop5.b_sat", 32'(bus_b.dropped_frame_count), 32'd3);

      cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd4);  lit_a("rel2",  4'b0100, 4'b1011, 1'b0);
      chk("rel2.count", 32'(bus_a.full_slot_count), 32'd3);
      cyc(1'b1, 1'b0, 4'd4, 4'd0, 4'd0);  lit_a("refill", 4'b0000, 4'b1111, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd2);  lit_a("rel1",  4'b0010, 4'b1101, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);  lit_a("rx1",   4'b0010, 4'b1101, 1'b1);
      cyc(1'b1, 1'b0, 4'd0, 4'd2, 4'd0);  lit_a("bad1",  4'b0010, 4'b1101, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);  lit_a("rxfs",  4'b0010, 4'b1101, 1'b1);
      chk("rxfs.drop", 32'(bus_a.dropped_frame_count), 32'd5);
      cyc(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);  lit_a("rxnoen", 4'b0010, 4'b1101, 1'b1);
      cyc(1'b0, 1'b0, 4'd2, 4'd0, 4'd0);  lit_a("gooddis", 4'b0000, 4'b1111, 1'b0);
      cyc(1'b0, 1'b0, 4'd0, 4'd0, 4'd1);  lit_a("reldis", 4'b0000, 4'b1110, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);  lit_a("rearm", 4'b0001, 4'b1110, 1'b0);

      // asynchronous reset in the middle of a frame
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      #2 reset_n = 1'b0;
      #1;
      lit_a("midreset", 4'b0000, 4'b0000, 1'b0);
      chk("midreset.drop", 32'(bus_a.dropped_frame_count), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);  lit_a("postreset", 4'b0001, 4'b0000, 1'b0);

      // randomized traffic, mostly aimed at the armed slot
      for (int k = 0; k < 4000; k++) begin
         logic e, f;
         logic [3:0] gg, bb, rr;
         e  = ($urandom_range(0, 9) != 0);
         f  = ($urandom_range(0, 3) == 0);
         gg = 4'($urandom) & 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 3) == 0) gg[m_a.ptr[1:0]] = 1'b1;
         bb = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 11) == 0) bb[m_a.ptr[1:0]] = 1'b1;
         rr = 4'($urandom) & 4'($urandom);
         cyc(e, f, gg, bb, rr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/receive_slot_scheduler.md
RECEIVE_SLOT_SCHEDULER -- requirements
Module: receive_slot_scheduler

Interface
REQ-001 Parameter RECEIVE_QUE_SLOTS, default 4, number of receive queue slots, legal range 1..8.
REQ-002 Parameter DROP_COUNT_WIDTH, default 16, width of dropped-frame counter.
REQ-003 clock  input  1  single block clock; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  permits arming of new slots.
REQ-006 frame_start  input  1  one-cycle pulse from parser at start of each received frame.
REQ-007 good_packet  input  RECEIVE_QUE_SLOTS  per-slot one-cycle pulse: frame in slot completed with CRC pass.
REQ-008 bad_packet  input  RECEIVE_QUE_SLOTS  per-slot one-cycle pulse: frame in slot aborted or CRC fail.
REQ-009 slot_release  input  RECEIVE_QUE_SLOTS  per-slot one-cycle pulse from fabric: slot contents consumed.
REQ-010 recieve_slot_enable  output  RECEIVE_QUE_SLOTS  one-hot or zero; slot the parser writes into.
REQ-011 slot_full  output  RECEIVE_QUE_SLOTS  per-slot flag: slot holds a good frame awaiting fabric.
REQ-012 full_slot_count  output  $clog2(RECEIVE_QUE_SLOTS+1)  population count of slot_full.
REQ-013 receiving  output  1  high while a frame is in progress in the armed slot.
REQ-014 dropped_frame_count  output  DROP_COUNT_WIDTH  saturating count of frames started with no slot armed.

Function
REQ-015 States SHALL be DISABLED, WAIT_SLOT, ARMED, RECEIVING; state and all outputs registered.
REQ-016 recieve_slot_enable SHALL be non-zero only in ARMED and RECEIVING, and then equal one-hot of armed pointer.
REQ-017 DISABLED: enable=1 and a free slot exists -> ARMED; enable=1 and none free -> WAIT_SLOT.
REQ-018 WAIT_SLOT: enable=0 -> DISABLED; a free slot exists (including one freed this cycle) -> ARMED next cycle.
REQ-019 ARMED: frame_start -> RECEIVING; enable=0 with no frame_start -> DISABLED, recieve_slot_enable=0 next cycle.
REQ-020 RECEIVING SHALL ignore enable; frame completes only via good_packet/bad_packet of the armed slot.
REQ-021 good_packet[k] for armed slot k in ARMED or RECEIVING: slot_full[k]=1 next cycle; pointer advances round-robin.
REQ-022 Round-robin search SHALL scan (k+1) mod N upward, wrapping, for first slot with slot_full=0 after applying same-cycle releases; found -> ARMED on it; none -> WAIT_SLOT (or DISABLED if enable=0).
REQ-023 bad_packet[k] for armed slot k: slot_full unchanged, pointer unchanged, state -> ARMED (DISABLED if enable=0) next cycle.
REQ-024 good_packet/bad_packet bits for non-armed slots, or in DISABLED/WAIT_SLOT, SHALL be ignored.
REQ-025 good_packet[k] and bad_packet[k] together SHALL be treated as bad_packet.
REQ-026 slot_release[j] SHALL clear slot_full[j] next cycle; release of a slot with slot_full=0 ignored.
REQ-027 Release and good_packet on different slots in the same cycle SHALL both take effect.
REQ-028 WAIT_SLOT re-arm search SHALL start at (last pointer+1) mod N.
REQ-029 frame_start in DISABLED or WAIT_SLOT SHALL increment dropped_frame_count by 1, saturating at all-ones; state unchanged.
REQ-030 frame_start in RECEIVING SHALL be ignored (no count, no state change).
REQ-031 full_slot_count SHALL equal popcount of slot_full in the same cycle.
REQ-032 receiving SHALL be 1 exactly in RECEIVING.
REQ-033 N=1: pointer fixed at 0; wrap search reduces to that slot.

Reset
REQ-034 reset_n low SHALL asynchronously force DISABLED, pointer=0, slot_full=0, recieve_slot_enable=0, full_slot_count=0, receiving=0, dropped_frame_count=0.
REQ-035 Reset mid-frame SHALL discard slot state; first arm after release of reset with enable=1 SHALL be slot 0.

Verification (N=4)
REQ-036 Reset release, enable=1 -> recieve_slot_enable=0001 one cycle later; frame_start -> receiving=1.
REQ-037 good_packet=0001 -> next cycle slot_full=0001, enable=0010, full_slot_count=1; repeat to fill all four -> enable=0000, WAIT_SLOT.
REQ-038 All full, slot_release=0100 -> next cycle slot_full=1011, enable=0100.
REQ-039 Armed slot 1, frame_start then bad_packet=0010 -> slot_full unchanged, enable stays 0010, receiving=0.
REQ-040 In WAIT_SLOT, three frame_start pulses -> dropped_frame_count=3; with DROP_COUNT_WIDTH=2, five pulses -> 3.
REQ-041 enable dropped during RECEIVING -> enable held until good_packet, then slot_full set and recieve_slot_enable=0000, DISABLED.
